// File: rtl/shift_register_universal_seq.sv
// Universal shift register with parallel load, rotate/arithmetic modes and a
// sequenced multi-step shift engine: one start command performs amt single-bit
// steps, one per enabled clock, reported through busy/done.
module shift_register_universal_seq #(
   parameter int WIDTH = 16,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] out,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] MODE_SHL  = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_ROL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ASR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [AW-1:0]    cnt_q,   cnt_d;
   logic [2:0]       mode_q,  mode_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   // One single-bit step of the captured operation; serial inputs are live.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       m,
      input logic             fill_l,
      input logic             fill_r
   );
      logic [WIDTH-1:0] r;
      r = d;
      case (m)
         MODE_SHL: r = {d[WIDTH-2:0], fill_r};
         MODE_SHR: r = {fill_l, d[WIDTH-1:1]};
         MODE_ROL: r = {d[WIDTH-2:0], d[WIDTH-1]};
         MODE_ROR: r = {d[0], d[WIDTH-1:1]};
         MODE_ASR: r = {d[WIDTH-1], d[WIDTH-1:1]};
         default:  r = d;
      endcase
      return r;
   endfunction

   // Command acceptance and step sequencing; done is a one-cycle pulse.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (mode == MODE_LOAD) begin
                     data_d = load_data;
                     done_d = 1'b1;
                  end else if (mode > MODE_LOAD || amt == '0) begin
                     // Reserved modes and zero-step commands complete at once.
                     done_d = 1'b1;
                  end else begin
                     mode_d  = mode;
                     cnt_d   = amt;
                     busy_d  = 1'b1;
                     state_d = SHIFT;
                  end
               end
            end
            SHIFT: begin
               data_d = shift_step(data_q, mode_q, sin_l, sin_r);
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == {{(AW-1){1'b0}}, 1'b1}) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; reset aborts any shift in progress without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out    = data_q;
   assign sout_l = data_q[WIDTH-1];
   assign sout_r = data_q[0];
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
